// File: rtl/la_jtag_pkg.sv
// Shared constants and types for the logic-analyser virtual JTAG controller.
// CTRL register field offsets are here so the LA core and host tooling agree on the layout.
package la_jtag_pkg;

  localparam logic IR_CTRL = 1'b0;
  localparam logic IR_DATA = 1'b1;

  typedef enum logic [1:0] {
    PF_EMPTY = 2'd0,
    PF_WAIT  = 2'd1,
    PF_FULL  = 2'd2
  } pf_state_t;

  // CTRL register layout
  localparam int RD_BASE_LSB   = 16;
  localparam int ARM_BIT       = 0;
  localparam int TRIG_EN_BIT   = 1;
  localparam int TRIG_EDGE_BIT = 2;
  localparam int TRIG_CH_LSB   = 4;
  localparam int TRIG_CH_W     = 4;

endpackage

// File: rtl/la_jtag_prefetch.sv
// Read pointer and one-word prefetch buffer in front of the sample memory.
// Keeps the next readout word ready so DR shifting never stalls at a word boundary.
module la_jtag_prefetch
  import la_jtag_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_ptr,
  input  logic [ADDR_W-1:0] ptr_val,
  input  logic              consume,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] pf_data,
  output logic              pf_full,
  output pf_state_t         pf_state
);

  // Memory handshake: mem_rd/mem_addr are sampled by the memory on a rising edge;
  // mem_rdata is valid for exactly the following cycle, with no backpressure.
  pf_state_t         state, state_nxt;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [DATA_W-1:0] pf_q, pf_q_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= PF_EMPTY;
      rd_ptr <= '0;
      pf_q   <= '0;
    end else begin
      state  <= state_nxt;
      rd_ptr <= rd_ptr_nxt;
      pf_q   <= pf_q_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rd_ptr_nxt = rd_ptr;
    pf_q_nxt   = pf_q;
    case (state)
      PF_EMPTY: begin
        rd_ptr_nxt = rd_ptr + ADDR_W'(1);
        state_nxt  = PF_WAIT;
      end
      PF_WAIT: begin
        // A consume here took mem_rdata straight through pf_data, so nothing is kept.
        if (consume) begin
          state_nxt = PF_EMPTY;
        end else begin
          pf_q_nxt  = mem_rdata;
          state_nxt = PF_FULL;
        end
      end
      PF_FULL: begin
        if (consume) state_nxt = PF_EMPTY;
      end
      default: state_nxt = PF_EMPTY;
    endcase
    // A new base address abandons whatever read is in flight.
    if (load_ptr) begin
      rd_ptr_nxt = ptr_val;
      pf_q_nxt   = pf_q;
      state_nxt  = PF_EMPTY;
    end
  end

  assign mem_rd   = (state == PF_EMPTY) && !rst;
  assign mem_addr = rd_ptr;
  assign pf_data  = (state == PF_WAIT) ? mem_rdata : pf_q;
  assign pf_full  = (state == PF_FULL);
  assign pf_state = state;

endmodule

// File: rtl/la_jtag_ctrl.sv
// Virtual JTAG DR chain for the logic analyser: IR=0 is the control/status register,
// IR=1 streams sample memory words back-to-back through the same shift register.
module la_jtag_ctrl
  import la_jtag_pkg::*;
#(
  parameter int CTRL_W = 32,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              tck,
  input  logic              rst,
  input  logic              tdi,
  output logic              tdo,
  input  logic              ir_in,
  output logic              ir_out,
  input  logic              vs_cdr,
  input  logic              vs_sdr,
  input  logic              vs_udr,
  input  logic              vs_uir,
  input  logic [CTRL_W-1:0] status_in,
  input  logic              data_ready,
  output logic [CTRL_W-1:0] ctrl_reg,
  output logic              ctrl_upd,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [CTRL_W-1:0] sr, sr_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic              cdr_hit, sdr_hit;
  logic              ctrl_udr, ctrl_cdr, ctrl_sdr;
  logic              data_cdr, data_sdr, word_end, consume;
  logic [DATA_W-1:0] pf_data;
  logic              pf_full;
  pf_state_t         pf_state;
  logic              unused_sink;

  // TAP states are exclusive; if several flags ever arrive together, udr > cdr > sdr.
  assign cdr_hit  = vs_cdr && !vs_udr;
  assign sdr_hit  = vs_sdr && !vs_cdr && !vs_udr;
  assign ctrl_udr = vs_udr  && (ir_in == IR_CTRL);
  assign ctrl_cdr = cdr_hit && (ir_in == IR_CTRL);
  assign ctrl_sdr = sdr_hit && (ir_in == IR_CTRL);
  assign data_cdr = cdr_hit && (ir_in == IR_DATA);
  assign data_sdr = sdr_hit && (ir_in == IR_DATA);
  assign word_end = data_sdr && (bit_cnt == LAST_BIT);
  assign consume  = data_cdr || word_end;

  la_jtag_prefetch #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_prefetch (
    .clk       (tck),
    .rst       (rst),
    .load_ptr  (ctrl_udr),
    .ptr_val   (sr[RD_BASE_LSB +: ADDR_W]),
    .consume   (consume),
    .mem_rdata (mem_rdata),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .pf_data   (pf_data),
    .pf_full   (pf_full),
    .pf_state  (pf_state)
  );

  always_comb begin
    sr_nxt      = sr;
    bit_cnt_nxt = bit_cnt;
    if (ctrl_cdr) begin
      sr_nxt = status_in;
    end else if (ctrl_sdr) begin
      sr_nxt = {tdi, sr[CTRL_W-1:1]};
    end else if (consume) begin
      // Reloading on the last shift keeps the stream gapless across words.
      sr_nxt[DATA_W-1:0] = pf_data;
      bit_cnt_nxt        = '0;
    end else if (data_sdr) begin
      sr_nxt[DATA_W-1:0] = {tdi, sr[DATA_W-1:1]};
      bit_cnt_nxt        = bit_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge tck or posedge rst) begin
    if (rst) begin
      sr       <= '0;
      bit_cnt  <= '0;
      ctrl_reg <= '0;
      ctrl_upd <= 1'b0;
    end else begin
      sr       <= sr_nxt;
      bit_cnt  <= bit_cnt_nxt;
      ctrl_upd <= ctrl_udr;
      if (ctrl_udr) ctrl_reg <= sr;
    end
  end

  assign tdo    = sr[0];
  assign ir_out = data_ready;

  // IR updates need no action here; prefetch status is observed only through pf_state.
  assign unused_sink = ^{vs_uir, pf_full, pf_state};

endmodule

// File: tb/tb_la_jtag_ctrl.sv
// Directed bench for la_jtag_ctrl: CTRL capture/update, gapless DATA streaming,
// address wrap, mid-word abandon and asynchronous reset.
module tb_la_jtag_ctrl;
  import la_jtag_pkg::*;

  localparam int CTRL_W = 32;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;

  logic              tck = 1'b0;
  logic              rst;
  logic              tdi;
  logic              tdo;
  logic              ir_in;
  logic              ir_out;
  logic              vs_cdr, vs_sdr, vs_udr, vs_uir;
  logic [CTRL_W-1:0] status_in;
  logic              data_ready;
  logic [CTRL_W-1:0] ctrl_reg;
  logic              ctrl_upd;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] obs_q[$];
  int                obs_cyc_q[$];
  logic [63:0]       d;

  la_jtag_ctrl #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .tck        (tck),
    .rst        (rst),
    .tdi        (tdi),
    .tdo        (tdo),
    .ir_in      (ir_in),
    .ir_out     (ir_out),
    .vs_cdr     (vs_cdr),
    .vs_sdr     (vs_sdr),
    .vs_udr     (vs_udr),
    .vs_uir     (vs_uir),
    .status_in  (status_in),
    .data_ready (data_ready),
    .ctrl_reg   (ctrl_reg),
    .ctrl_upd   (ctrl_upd),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata)
  );

  // clock / reset
  always #5 tck = ~tck;

  // sample memory holding addr*0x0101, one-cycle read latency; logs every read
  function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    logic [31:0] p;
    p = 32'(a) * 32'h0101;
    return p[DATA_W-1:0];
  endfunction

  always @(posedge tck) begin
    if (mem_rd) begin
      mem_rdata <= word_of(mem_addr);
      obs_q.push_back(mem_addr);
      obs_cyc_q.push_back(cyc);
    end
    cyc = cyc + 1;
  end

  // driver tasks
  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic pulse_cdr();
    vs_cdr = 1'b1;
    tick();
    vs_cdr = 1'b0;
  endtask

  task automatic pulse_udr();
    vs_udr = 1'b1;
    tick();
    vs_udr = 1'b0;
  endtask

  task automatic shift_bits(input int n, input logic [63:0] din, output logic [63:0] dout);
    dout   = '0;
    vs_sdr = 1'b1;
    for (int i = 0; i < n; i++) begin
      tdi     = din[i];
      dout[i] = tdo;
      tick();
    end
    vs_sdr = 1'b0;
    tdi    = 1'b0;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_reads();
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  task automatic check_reads(input string tag);
    logic [ADDR_W-1:0] e;
    check({tag, "_cnt"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) check(tag, 64'(obs_q.pop_front()), 64'(e));
      else                  check(tag, 'x, 64'(e));
    end
    clear_reads();
  endtask

  initial begin
    rst        = 1'b1;
    tdi        = 1'b0;
    ir_in      = IR_CTRL;
    vs_cdr     = 1'b0;
    vs_sdr     = 1'b0;
    vs_udr     = 1'b0;
    vs_uir     = 1'b0;
    status_in  = '0;
    data_ready = 1'b0;

    // 1: reset values, then a single prefetch of address 0
    repeat (3) tick();
    check("rst_tdo",      tdo,      0);
    check("rst_ctrl_reg", ctrl_reg, 0);
    check("rst_ctrl_upd", ctrl_upd, 0);
    check("rst_mem_rd",   mem_rd,   0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    clear_reads();
    repeat (4) tick();
    exp_q.push_back(10'd0);
    check_reads("rst_rd");

    // ir_out follows data_ready
    data_ready = 1'b1;
    #1 check("ir_out_1", ir_out, 1);
    data_ready = 1'b0;
    #1 check("ir_out_0", ir_out, 0);

    // 2: status capture shifted out LSB first
    status_in = 32'hA5A5_0001;
    pulse_cdr();
    check("cdr_tdo0", tdo, 1);
    shift_bits(32, 64'h0, d);
    check("ctrl_status", d[31:0], 32'hA5A5_0001);

    // 3: write base address 3 through the CTRL DR
    clear_reads();
    shift_bits(32, 64'h0003_0000, d);
    check("ctrl_pre_udr", ctrl_reg, 0);
    pulse_udr();
    check("udr_ctrl_reg", ctrl_reg, 32'h0003_0000);
    check("udr_ctrl_upd", ctrl_upd, 1);
    check("udr_mem_rd",   mem_rd,   1);
    check("udr_mem_addr", mem_addr, 3);
    tick();
    check("upd_pulse_end", ctrl_upd, 0);
    tick();

    // 4: three gapless words 3,4,5; reads issued one word apart
    ir_in = IR_DATA;
    pulse_cdr();
    shift_bits(48, 64'h0, d);
    check("stream_3_4_5", d[47:0], 48'h0505_0404_0303);
    check("rd_spacing_a", obs_cyc_q.size() >= 4 ? 64'(obs_cyc_q[2] - obs_cyc_q[1]) : 64'hFFFF, 16);
    check("rd_spacing_b", obs_cyc_q.size() >= 4 ? 64'(obs_cyc_q[3] - obs_cyc_q[2]) : 64'hFFFF, 16);
    exp_q.push_back(10'd3);
    exp_q.push_back(10'd4);
    exp_q.push_back(10'd5);
    exp_q.push_back(10'd6);
    check_reads("stream_rd");

    // UDR in DATA mode leaves the control register alone
    pulse_udr();
    check("data_udr_reg", ctrl_reg, 32'h0003_0000);
    check("data_udr_upd", ctrl_upd, 0);

    // 5: base 1023 wraps to 0
    ir_in = IR_CTRL;
    shift_bits(32, 64'h03FF_0000, d);
    clear_reads();
    pulse_udr();
    check("wrap_mem_addr", mem_addr, 10'd1023);
    repeat (2) tick();
    ir_in = IR_DATA;
    pulse_cdr();
    shift_bits(48, 64'h0, d);
    check("stream_wrap", d[47:0], 48'h0101_0000_02FF);
    exp_q.push_back(10'd1023);
    exp_q.push_back(10'd0);
    exp_q.push_back(10'd1);
    exp_q.push_back(10'd2);
    check_reads("wrap_rd");

    // 6: abandon word 2 after 5 bits; next capture resumes at word 3
    shift_bits(5, 64'h0, d);
    check("partial_w2", d[4:0], 5'b00010);
    repeat (2) tick();
    pulse_cdr();
    shift_bits(16, 64'h0, d);
    check("resume_w3", d[15:0], 16'h0303);

    // asynchronous reset in the middle of word 4
    shift_bits(2, 64'h0, d);
    check("pre_rst_tdo", tdo, 1);
    vs_sdr = 1'b1;
    @(posedge tck);
    #3 rst = 1'b1;
    #1;
    check("arst_tdo",      tdo,      0);
    check("arst_ctrl_reg", ctrl_reg, 0);
    check("arst_ctrl_upd", ctrl_upd, 0);
    check("arst_mem_rd",   mem_rd,   0);
    check("arst_mem_addr", mem_addr, 0);
    vs_sdr = 1'b0;
    tick();
    rst = 1'b0;
    clear_reads();
    repeat (4) tick();
    exp_q.push_back(10'd0);
    check_reads("arst_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
